// File: rtl/xbar_output_arbiter_if.sv
// Valid/ready bundle between NUM_IN crossbar input streams and one egress sink.
// The master modport is the arbiter side; slave is the upstream/sink environment.
interface xbar_output_arbiter_if #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 32,
    parameter int SRC_W  = $clog2(NUM_IN)
);
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_last;
    logic [NUM_IN-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic [SRC_W-1:0]         out_src;
    logic                     out_ready;

    modport master (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_src
    );

    modport slave (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_src
    );
endinterface

// File: rtl/xbar_output_arbiter.sv
// Crossbar egress arbiter: round-robin pick among NUM_IN streams, grant held
// for a whole packet, single registered valid/ready stage toward the sink.
module xbar_output_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 32,
    parameter int SRC_W  = $clog2(NUM_IN)
) (
    input logic                   clk,
    input logic                   rst_n,
    xbar_output_arbiter_if.master bus
);
    localparam int unsigned NUM_IN_U = NUM_IN;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state;
    logic [SRC_W-1:0]  grant;
    logic [SRC_W-1:0]  last_grant;
    logic [SRC_W-1:0]  scan_pick;
    logic              scan_hit;
    logic              take_ok;
    logic              accept;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;

    // Round-robin scan starting one past the previous packet's owner.
    always_comb begin
        int unsigned idx;
        scan_pick = '0;
        scan_hit  = 1'b0;
        for (int unsigned k = 1; k <= NUM_IN_U; k++) begin
            idx = (32'(last_grant) + k) % NUM_IN_U;
            if (!scan_hit && bus.in_valid[SRC_W'(idx)]) begin
                scan_hit  = 1'b1;
                scan_pick = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_IN_U; i++) begin
            if (SRC_W'(i) == grant) begin
                sel_data = bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_last = bus.in_last[grant];
    assign take_ok  = (state == LOCKED) && (!bus.out_valid || bus.out_ready);
    assign accept   = take_ok && bus.in_valid[grant];

    always_comb begin
        bus.in_ready = '0;
        if (take_ok) begin
            bus.in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= SRC_W'(NUM_IN - 1);
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_src   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (scan_hit) begin
                        grant <= scan_pick;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && sel_last) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Output stage: load on accept, otherwise drain when the sink takes it.
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= sel_data;
                bus.out_last  <= sel_last;
                bus.out_src   <= grant;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_xbar_output_arbiter.sv
// Directed bench for xbar_output_arbiter: queued upstream beats, collected
// sink transfers, hand-computed expectations checked with immediate assertions.
module tb_xbar_output_arbiter;
    localparam int NUM_IN = 4;
    localparam int DATA_W = 32;
    localparam int SRC_W  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    xbar_output_arbiter_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .SRC_W(SRC_W)) bus ();

    xbar_output_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [32:0]       srcq [NUM_IN][$];
    logic [34:0]       obs [$];
    logic [NUM_IN-1:0] mute;
    int                vectors     = 0;
    int                miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_IN; i++) begin
            if (srcq[i].size() > 0 && !mute[i]) begin
                bus.in_valid[i]                  = 1'b1;
                bus.in_data[i*DATA_W +: DATA_W]  = srcq[i][0][31:0];
                bus.in_last[i]                   = srcq[i][0][32];
            end else begin
                bus.in_valid[i]                  = 1'b0;
                bus.in_data[i*DATA_W +: DATA_W]  = '0;
                bus.in_last[i]                   = 1'b0;
            end
        end
    endtask

    task automatic push(input int i, input logic l, input logic [31:0] d);
        srcq[i].push_back({l, d});
        drive();
    endtask

    // One clock: sample handshakes settled before the rising edge, advance at the falling edge.
    task automatic tick();
        logic [NUM_IN-1:0] f;
        #1;
        f = bus.in_valid & bus.in_ready;
        if (bus.out_valid && bus.out_ready)
            obs.push_back({bus.out_src, bus.out_last, bus.out_data});
        @(negedge clk);
        for (int i = 0; i < NUM_IN; i++)
            if (f[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        drive();
    endtask

    task automatic expect_beat(input string tag, input logic [1:0] s, input logic l, input logic [31:0] d);
        chk({tag, "_present"}, 64'(obs.size() > 0), 64'd1);
        if (obs.size() > 0) chk(tag, 64'(obs.pop_front()), 64'({s, l, d}));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mute  = '0;
        for (int i = 0; i < NUM_IN; i++) srcq[i].delete();
        drive();
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        mute  = '0;
        bus.out_ready = 1'b1;
        drive();

        // Reset state
        do_reset();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        chk("rst_out_src",   64'(bus.out_src),   64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);

        // A: single beat on input 0
        push(0, 1'b1, 32'hA5);
        tick();
        chk("A_in_ready_c2", 64'(bus.in_ready), 64'b0001);
        chk("A_out_valid_c2", 64'(bus.out_valid), 64'd0);
        tick();
        chk("A_out_valid_c3", 64'(bus.out_valid), 64'd1);
        chk("A_out_data_c3",  64'(bus.out_data),  64'hA5);
        chk("A_out_src_c3",   64'(bus.out_src),   64'd0);
        chk("A_out_last_c3",  64'(bus.out_last),  64'd1);
        chk("A_in_ready_c3",  64'(bus.in_ready),  64'd0);
        tick();
        chk("A_out_valid_c4", 64'(bus.out_valid), 64'd0);
        expect_beat("A_beat", 2'd0, 1'b1, 32'hA5);

        // B: all inputs request continuously from fresh reset
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_IN; i++) push(i, 1'b1, 32'hB0 + 32'(16*r + i));
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk($sformatf("B_out_valid_t%0d", k), 64'(bus.out_valid), 64'((k % 2 == 0) && (k <= 16)));
        end
        for (int n = 0; n < 8; n++)
            expect_beat($sformatf("B_beat%0d", n), 2'(n % 4), 1'b1, 32'hB0 + 32'(16*(n/4) + n%4));
        chk("B_nodup", 64'(obs.size()), 64'd0);

        // C: 3-beat packet on input 1, input 2 waiting
        push(1, 1'b0, 32'h11);
        push(1, 1'b0, 32'h12);
        push(1, 1'b1, 32'h13);
        push(2, 1'b1, 32'h21);
        tick();
        tick();
        chk("C_in_ready_locked", 64'(bus.in_ready), 64'b0010);
        repeat (5) tick();
        expect_beat("C_beat0", 2'd1, 1'b0, 32'h11);
        expect_beat("C_beat1", 2'd1, 1'b0, 32'h12);
        expect_beat("C_beat2", 2'd1, 1'b1, 32'h13);
        expect_beat("C_beat3", 2'd2, 1'b1, 32'h21);
        chk("C_nodup", 64'(obs.size()), 64'd0);

        // D: backpressure after beat 2 of a 4-beat packet on input 3
        push(3, 1'b0, 32'h31);
        push(3, 1'b0, 32'h32);
        push(3, 1'b0, 32'h33);
        push(3, 1'b1, 32'h34);
        repeat (3) tick();
        bus.out_ready = 1'b0;
        #1;
        chk("D_in_ready_bp", 64'(bus.in_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("D_hold_data%0d", k),  64'(bus.out_data),  64'h32);
            chk($sformatf("D_hold_valid%0d", k), 64'(bus.out_valid), 64'd1);
            chk($sformatf("D_hold_ready%0d", k), 64'(bus.in_ready),  64'd0);
        end
        bus.out_ready = 1'b1;
        repeat (3) tick();
        expect_beat("D_beat0", 2'd3, 1'b0, 32'h31);
        expect_beat("D_beat1", 2'd3, 1'b0, 32'h32);
        expect_beat("D_beat2", 2'd3, 1'b0, 32'h33);
        expect_beat("D_beat3", 2'd3, 1'b1, 32'h34);
        chk("D_nodup", 64'(obs.size()), 64'd0);

        // E: wrap-around after a grant to input 3
        push(3, 1'b1, 32'h3A);
        repeat (2) tick();
        push(0, 1'b1, 32'h0A);
        push(3, 1'b1, 32'h3B);
        repeat (2) tick();
        chk("E_wrap_src", 64'(bus.out_src), 64'd0);
        repeat (3) tick();
        expect_beat("E_beat0", 2'd3, 1'b1, 32'h3A);
        expect_beat("E_beat1", 2'd0, 1'b1, 32'h0A);
        expect_beat("E_beat2", 2'd3, 1'b1, 32'h3B);
        chk("E_nodup", 64'(obs.size()), 64'd0);

        // F: in_valid dropped mid-packet on input 1
        push(1, 1'b0, 32'h51);
        push(1, 1'b1, 32'h52);
        repeat (2) tick();
        mute[1] = 1'b1;
        drive();
        tick();
        chk("F_gap_ready0", 64'(bus.in_ready),  64'b0010);
        chk("F_gap_valid0", 64'(bus.out_valid), 64'd0);
        tick();
        chk("F_gap_ready1", 64'(bus.in_ready),  64'b0010);
        mute[1] = 1'b0;
        drive();
        repeat (2) tick();
        expect_beat("F_beat0", 2'd1, 1'b0, 32'h51);
        expect_beat("F_beat1", 2'd1, 1'b1, 32'h52);
        chk("F_nodup", 64'(obs.size()), 64'd0);

        // G: reset asserted on beat 2 of 4, then priority pointer back at input 0
        push(0, 1'b0, 32'h61);
        push(0, 1'b0, 32'h62);
        push(0, 1'b0, 32'h63);
        push(0, 1'b1, 32'h64);
        repeat (3) tick();
        chk("G_pre_data", 64'(bus.out_data), 64'h62);
        expect_beat("G_beat0", 2'd0, 1'b0, 32'h61);
        rst_n = 1'b0;
        #1;
        chk("G_async_valid", 64'(bus.out_valid), 64'd0);
        chk("G_async_data",  64'(bus.out_data),  64'd0);
        chk("G_async_ready", 64'(bus.in_ready),  64'd0);
        for (int i = 0; i < NUM_IN; i++) srcq[i].delete();
        drive();
        tick();
        rst_n = 1'b1;
        obs.delete();
        push(2, 1'b1, 32'h72);
        push(0, 1'b1, 32'h02);
        tick();
        chk("G_post_ready", 64'(bus.in_ready), 64'b0001);
        repeat (4) tick();
        expect_beat("G_beat1", 2'd0, 1'b1, 32'h02);
        expect_beat("G_beat2", 2'd2, 1'b1, 32'h72);
        chk("G_nodup", 64'(obs.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
